// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP/PC1 on accept, one Feistel round per clock via an external F-function, FP on exit.
// Decryption (right-rotation key schedule) is built only when DES_DECRYPT_EN is defined.
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic [31:0] f_r,
  output logic [47:0] f_k,
  input  logic [31:0] f_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);

  if (ROUNDS != 16) begin : g_rounds_check
    $fatal(1, "des_round_sequencer: ROUNDS must be 16");
  end

  // state | meaning
  // IDLE  | in_ready high, waiting for a block/key
  // RUN   | one Feistel round per clock, rnd = 0..15
  // HOLD  | out_valid high, out_block stable until out_ready
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    logic [27:0] y;
    case (s)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    logic [27:0] y;
    case (s)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction
`endif

  state_t state, state_nxt;

  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [3:0]  rnd;
  logic        accept;
  logic        last_rnd;
  logic        one_shift;
  logic [1:0]  shamt;
  logic [27:0] c_rot, d_rot;
  logic [55:0] cd_rot;
  logic [31:0] r_new;
  logic [63:0] ip_o;
  logic [55:0] pc1_o;
  logic [47:0] pc2_o;
  logic [63:0] fp_i, fp_o;

  for (genvar i = 0; i < 64; i++) begin : g_ip_fp
    assign ip_o[63-i] = in_block[64-IP_T[i]];
    assign fp_o[63-i] = fp_i[64-FP_T[i]];
  end

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_o[55-i] = in_key[64-PC1_T[i]];
  end

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2_o[47-i] = cd_rot[56-PC2_T[i]];
  end

  assign accept    = in_valid & in_ready;
  assign last_rnd  = (rnd == 4'(ROUNDS - 1));
  assign one_shift = (rnd == 4'd0) | (rnd == 4'd1) | (rnd == 4'd8) | (rnd == 4'd15);
  assign cd_rot    = {c_rot, d_rot};
  assign r_new     = l ^ f_out;
  assign fp_i      = {r_new, r};
  assign f_r       = r;
  assign f_k       = pc2_o;

`ifdef DES_DECRYPT_EN
  logic dec;

  // Decrypt walks C/D backwards from C16/D16 (== C0/D0), so round 0 rotates by zero.
  always_comb begin
    shamt = one_shift ? 2'd1 : 2'd2;
    c_rot = rotl28(c, shamt);
    d_rot = rotl28(d, shamt);
    if (dec) begin
      shamt = (rnd == 4'd0) ? 2'd0 : (one_shift ? 2'd1 : 2'd2);
      c_rot = rotr28(c, shamt);
      d_rot = rotr28(d, shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec <= 1'b0;
    end else if (accept) begin
      dec <= in_decrypt;
    end
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = in_decrypt;

  always_comb begin
    shamt = one_shift ? 2'd1 : 2'd2;
    c_rot = rotl28(c, shamt);
    d_rot = rotl28(d, shamt);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_rnd) state_nxt = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      rnd       <= '0;
      out_block <= '0;
    end else if (accept) begin
      l   <= ip_o[63:32];
      r   <= ip_o[31:0];
      c   <= pc1_o[55:28];
      d   <= pc1_o[27:0];
      rnd <= '0;
    end else if (state == RUN) begin
      c   <= c_rot;
      d   <= d_rot;
      l   <= r;
      r   <= r_new;
      rnd <= rnd + 4'd1;
      // Final swap: output is FP(R16 || L16).
      if (last_rnd) out_block <= fp_o;
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized bench for des_round_sequencer: a plain DES reference model plus the F-function the engine drives.
module tb_des_round_sequencer;

`ifdef DES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_decrypt;
  logic [63:0] in_block, in_key;
  logic [31:0] f_r, f_out;
  logic [47:0] f_k;
  logic        out_valid, out_ready, busy;
  logic [63:0] out_block;

  int          vectors = 0;
  int          miscompares = 0;
  logic [47:0] exp_k [16];
  logic [31:0] exp_r [16];
  logic [63:0] exp_out;
  logic [63:0] last_out;
  logic [47:0] first_fk;

  always #5 clk = ~clk;

  function automatic logic [63:0] t_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] t_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction
  function automatic logic [55:0] t_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] t_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = {six[5], six[0]};
      col = six[4:1];
      s[31-4*b -: 4] = 4'(SB[b*64 + row*16 + col]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  assign f_out = des_f(f_r, f_k);

  des_round_sequencer #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
    .f_r(f_r), .f_k(f_k), .f_out(f_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Textbook DES: full key schedule first, then 16 rounds; decrypt uses the schedule reversed.
  task automatic ref_des(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] b;
    logic [31:0] l, r, t;
    logic [47:0] k;
    cd = t_pc1(key);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < SHIFTS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = t_pc2({c, d});
    end
    b = t_ip(blk);
    l = b[63:32];
    r = b[31:0];
    for (int i = 0; i < 16; i++) begin
      k = (dec && DEC_EN) ? ks[15-i] : ks[i];
      exp_k[i] = k;
      exp_r[i] = r;
      t = l ^ des_f(r, k);
      l = r;
      r = t;
    end
    exp_out = t_fp({r, l});
  endtask

  task automatic run_block(input logic [63:0] key, input logic [63:0] blk, input logic dec, input int hold);
    int          cyc, busy_cnt, bad, unstable;
    logic [63:0] held;
    ref_des(key, blk, dec);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_key = key; in_block = blk; in_decrypt = dec;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_key = {$urandom(), $urandom()}; in_block = {$urandom(), $urandom()};
    in_decrypt = ~dec;
    cyc = 0; busy_cnt = 0; bad = 0; first_fk = 'x;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (cyc == 1) first_fk = f_k;
      if (cyc <= 16 && (f_k !== exp_k[cyc-1] || f_r !== exp_r[cyc-1])) bad++;
    end
    chk("latency", 64'(cyc), 64'd17);
    chk("round_fk_fr", 64'(bad), 64'd0);
    chk("result", out_block, exp_out);
    last_out = out_block;
    held = out_block;
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        in_valid = 1'b1; in_block = {$urandom(), $urandom()}; in_key = {$urandom(), $urandom()};
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (busy) busy_cnt++;
      if (!out_valid || in_ready || out_block !== held) unstable++;
    end
    if (hold > 0) chk("backpressure_hold", 64'(unstable), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("busy_cycles", 64'(busy_cnt), 64'(17 + hold));
    chk("back_to_idle", {61'd0, busy, out_valid, in_ready}, 64'd1);
  endtask

  task automatic reset_mid_run();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_key = {$urandom(), $urandom()}; in_block = {$urandom(), $urandom()};
    in_decrypt = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", {61'd0, busy, out_valid, in_ready}, 64'd1);
    chk("rst_mid_out_block", out_block, 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    chk("no_partial_result", 64'(seen), 64'd0);
  endtask

  task automatic back_to_back();
    logic [63:0] ka, ba, kb, bb, exp_a, exp_b, res_a;
    int          n, m;
    ka = {$urandom(), $urandom()}; ba = {$urandom(), $urandom()};
    kb = {$urandom(), $urandom()}; bb = {$urandom(), $urandom()};
    ref_des(ka, ba, 1'b0); exp_a = exp_out;
    ref_des(kb, bb, 1'b0); exp_b = exp_out;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_key = ka; in_block = ba; in_decrypt = 1'b0;
    @(posedge clk);
    #1;
    in_key = kb; in_block = bb;
    n = 0; res_a = '0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid) res_a = out_block;
    end while (!in_ready && n < 40);
    chk("b2b_accept_spacing", 64'(n), 64'd18);
    chk("b2b_first", res_a, exp_a);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_key = {$urandom(), $urandom()}; in_block = {$urandom(), $urandom()};
    m = 0;
    while (!out_valid && m < 40) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_second_latency", 64'(m), 64'd17);
    chk("b2b_second", out_block, exp_b);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_key = '0; in_decrypt = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {61'd0, busy, out_valid, in_ready}, 64'd1);
    chk("reset_out_block", out_block, 64'd0);
    rst = 1'b0;

    run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0);
    chk("kat_enc", last_out, 64'h85E813540F0AB405);
    run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 0);
`ifdef DES_DECRYPT_EN
    chk("kat_dec", last_out, 64'h0123456789ABCDEF);
`endif
    run_block(64'd0, 64'd0, 1'b0, 0);
    chk("kat_zero", last_out, 64'h8CA64DE9C1B123A7);
    chk("fk_round0_zero", {16'd0, first_fk}, 64'd0);

    run_block({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 5);

    reset_mid_run();
    run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 0);
    chk("kat_after_reset", last_out, 64'h85E813540F0AB405);

    back_to_back();

    for (int n = 0; n < 10; n++)
      run_block({$urandom(), $urandom()}, {$urandom(), $urandom()},
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
